// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch requester and a load/store requester onto one memory port, one transaction at a time.
// Optional macro FETCH_STARVE_GUARD_EN: after four consecutive mem grants that bypassed a waiting fetch, fetch wins.
`timescale 1ns/1ps
module mem_port_arbiter (
    input  logic        clk_i,
    input  logic        rst_n_i,
    // fetch side
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_valid_o,
    output logic [31:0] if_rdata_o,
    input  logic        flush_i,
    output logic        fetch_stall_o,
    // data side
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_gnt_o,
    output logic        mem_valid_o,
    output logic [31:0] mem_rdata_o,
    // shared port
    output logic        port_req_o,
    output logic        port_we_o,
    output logic [31:0] port_addr_o,
    output logic [31:0] port_wdata_o,
    input  logic        port_ready_i,
    input  logic        port_valid_i,
    input  logic [31:0] port_rdata_i,
    // FSM state for observation: 0 IDLE, 1 ISSUE, 2 WAIT
    output logic [1:0]  dbg_state_o
);

    // Handshake: port_req_o stays high with stable fields until a cycle with port_ready_i=1
    // (accept); the response is the first cycle after accept with port_valid_i=1.
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
    typedef enum logic {OWN_FETCH = 1'b0, OWN_MEM = 1'b1} owner_t;

    state_t      state_q, state_d;
    owner_t      owner_q;
    logic        first_q;
    logic        drop_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        if_valid_q, mem_valid_q;
    logic [31:0] if_rdata_q, mem_rdata_q;

    logic        arb_go;
    logic        arb_mem;
    logic        fetch_forced;
    logic        rsp_done;
    logic        drop_now;

`ifdef FETCH_STARVE_GUARD_EN
    logic [2:0] starve_q;

    assign fetch_forced = if_req_i && (starve_q == 3'd4);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_q <= 3'd0;
        end else if (state_q == IDLE) begin
            if (!if_req_i)
                starve_q <= 3'd0;
            else if (arb_go && arb_mem)
                starve_q <= starve_q + 3'd1;
            else if (arb_go)
                starve_q <= 3'd0;
        end
    end
`else
    assign fetch_forced = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        arb_go  = 1'b0;
        arb_mem = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req_i || if_req_i) begin
                    arb_go  = 1'b1;
                    arb_mem = mem_req_i && !fetch_forced;
                    state_d = ISSUE;
                end
            end
            ISSUE: if (port_ready_i) state_d = WAIT;
            WAIT:  if (port_valid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rsp_done = (state_q == WAIT) && port_valid_i;
    // A flush in the response cycle itself must still suppress that response.
    assign drop_now = drop_q || (flush_i && (owner_q == OWN_FETCH) && (state_q != IDLE));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            owner_q     <= OWN_FETCH;
            first_q     <= 1'b0;
            drop_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            first_q     <= arb_go;
            if_valid_q  <= rsp_done && (owner_q == OWN_FETCH) && !drop_now;
            mem_valid_q <= rsp_done && (owner_q == OWN_MEM);
            if (arb_go) begin
                owner_q <= arb_mem ? OWN_MEM : OWN_FETCH;
                addr_q  <= arb_mem ? mem_addr_i : if_addr_i;
                we_q    <= arb_mem && mem_we_i;
                wdata_q <= arb_mem ? mem_wdata_i : 32'h0;
            end
            if (rsp_done || state_q == IDLE)
                drop_q <= 1'b0;
            else if (flush_i && owner_q == OWN_FETCH)
                drop_q <= 1'b1;
            if (rsp_done && owner_q == OWN_FETCH && !drop_now)
                if_rdata_q <= port_rdata_i;
            // Writes are acknowledged but leave the last read data in place.
            if (rsp_done && owner_q == OWN_MEM && !we_q)
                mem_rdata_q <= port_rdata_i;
        end
    end

    assign if_gnt_o      = (state_q == ISSUE) && first_q && (owner_q == OWN_FETCH);
    assign mem_gnt_o     = (state_q == ISSUE) && first_q && (owner_q == OWN_MEM);
    assign port_req_o    = (state_q == ISSUE);
    assign port_we_o     = (state_q == ISSUE) && we_q;
    assign port_addr_o   = addr_q;
    assign port_wdata_o  = wdata_q;
    assign if_valid_o    = if_valid_q;
    assign if_rdata_o    = if_rdata_q;
    assign mem_valid_o   = mem_valid_q;
    assign mem_rdata_o   = mem_rdata_q;
    assign fetch_stall_o = if_req_i && !if_valid_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: transaction-level model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        if_req_i, flush_i, mem_req_i, mem_we_i;
    logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i;
    logic        if_gnt_o, if_valid_o, fetch_stall_o, mem_gnt_o, mem_valid_o;
    logic [31:0] if_rdata_o, mem_rdata_o;
    logic        port_req_o, port_we_o, port_ready_i, port_valid_i;
    logic [31:0] port_addr_o, port_wdata_o, port_rdata_i;
    logic [1:0]  dbg_state_o;

    int n_tests = 0;
    int n_fail  = 0;

    // responder configuration
    int          ready_wait = 0;
    int          rsp_gap    = 0;
    bit          auto_rsp   = 1'b1;
    logic [31:0] rsp_data   = 32'h0;

    mem_port_arbiter dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o), .flush_i(flush_i),
        .fetch_stall_o(fetch_stall_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_gnt_o(mem_gnt_o), .mem_valid_o(mem_valid_o),
        .mem_rdata_o(mem_rdata_o),
        .port_req_o(port_req_o), .port_we_o(port_we_o), .port_addr_o(port_addr_o),
        .port_wdata_o(port_wdata_o), .port_ready_i(port_ready_i),
        .port_valid_i(port_valid_i), .port_rdata_i(port_rdata_i),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    task automatic check1(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic neg();
        @(negedge clk_i);
    endtask

    // ---------------- port responder ----------------
    initial begin
        int  age;
        bit  acc, rsp_armed;
        int  rsp_left;
        age = 0; acc = 0; rsp_armed = 0; rsp_left = 0;
        port_ready_i = 1'b0;
        port_valid_i = 1'b0;
        port_rdata_i = 32'h0;
        forever begin
            step();
            if (!rst_n_i || !auto_rsp) begin
                age = 0; acc = 0; rsp_armed = 0;
                if (auto_rsp) begin
                    port_ready_i = 1'b0;
                    port_valid_i = 1'b0;
                end
                continue;
            end
            port_valid_i = 1'b0;
            if (acc) begin
                rsp_armed = 1;
                rsp_left  = rsp_gap;
            end
            if (rsp_armed) begin
                if (rsp_left == 0) begin
                    port_valid_i = 1'b1;
                    port_rdata_i = rsp_data;
                    rsp_armed    = 0;
                end else begin
                    rsp_left--;
                end
            end
            if (port_req_o) age++; else age = 0;
            port_ready_i = port_req_o && (age > ready_wait);
            acc = port_req_o && port_ready_i;
        end
    end

    // ---------------- transaction model and per-cycle compare ----------------
    bit          tx_open, tx_first, tx_acc, tx_drop, tx_mem, tx_we;
    logic [31:0] tx_addr, tx_wdata;
    bit          e_if_valid, e_mem_valid;
    logic [31:0] e_if_rdata, e_mem_rdata;
    int          starve_n;

    initial begin
        bit n_if_valid, n_mem_valid;
        forever begin
            neg();
            if (!rst_n_i) begin
                tx_open = 0; tx_first = 0; tx_acc = 0; tx_drop = 0;
                e_if_valid = 0; e_mem_valid = 0;
                e_if_rdata = 32'h0; e_mem_rdata = 32'h0;
                starve_n = 0;
                check1("rst_port_req", port_req_o, 1'b0);
                check1("rst_port_we", port_we_o, 1'b0);
                check32("rst_port_addr", port_addr_o, 32'h0);
                check32("rst_port_wdata", port_wdata_o, 32'h0);
                check1("rst_if_gnt", if_gnt_o, 1'b0);
                check1("rst_mem_gnt", mem_gnt_o, 1'b0);
                check1("rst_if_valid", if_valid_o, 1'b0);
                check1("rst_mem_valid", mem_valid_o, 1'b0);
                check32("rst_if_rdata", if_rdata_o, 32'h0);
                check32("rst_mem_rdata", mem_rdata_o, 32'h0);
                check1("rst_stall", fetch_stall_o, if_req_i);
                continue;
            end
            // compare this cycle
            check1("m_port_req", port_req_o, tx_open && !tx_acc);
            if (tx_open && !tx_acc) begin
                check32("m_port_addr", port_addr_o, tx_addr);
                check1("m_port_we", port_we_o, tx_we);
                if (tx_we) check32("m_port_wdata", port_wdata_o, tx_wdata);
            end else begin
                check1("m_port_we_idle", port_we_o, 1'b0);
            end
            check1("m_if_gnt", if_gnt_o, tx_open && tx_first && !tx_mem);
            check1("m_mem_gnt", mem_gnt_o, tx_open && tx_first && tx_mem);
            check1("m_if_valid", if_valid_o, e_if_valid);
            check1("m_mem_valid", mem_valid_o, e_mem_valid);
            check32("m_if_rdata", if_rdata_o, e_if_rdata);
            check32("m_mem_rdata", mem_rdata_o, e_mem_rdata);
            check1("m_stall", fetch_stall_o, if_req_i && !e_if_valid);
            // advance the model using this cycle's inputs
            n_if_valid = 0; n_mem_valid = 0;
            if (tx_open) begin
                tx_first = 0;
                if (!tx_mem && flush_i) tx_drop = 1;
                if (!tx_acc) begin
                    if (port_ready_i) tx_acc = 1;
                end else if (port_valid_i) begin
                    if (!tx_mem) begin
                        if (!tx_drop) begin
                            n_if_valid = 1;
                            e_if_rdata = port_rdata_i;
                        end
                    end else begin
                        n_mem_valid = 1;
                        if (!tx_we) e_mem_rdata = port_rdata_i;
                    end
                    tx_open = 0;
                end
            end else begin
`ifdef FETCH_STARVE_GUARD_EN
                if (!if_req_i) starve_n = 0;
`endif
                if (mem_req_i || if_req_i) begin
                    tx_mem = mem_req_i;
`ifdef FETCH_STARVE_GUARD_EN
                    if (if_req_i && starve_n >= 4) tx_mem = 0;
                    if (tx_mem && if_req_i) starve_n++; else starve_n = 0;
`endif
                    tx_open  = 1; tx_first = 1; tx_acc = 0; tx_drop = 0;
                    tx_addr  = tx_mem ? mem_addr_i : if_addr_i;
                    tx_we    = tx_mem && mem_we_i;
                    tx_wdata = mem_wdata_i;
                end
            end
            e_if_valid  = n_if_valid;
            e_mem_valid = n_mem_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic mem_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rd, input logic [31:0] exp_rdata, input bit fl);
        int n;
        step();
        rsp_data = rd; mem_req_i = 1; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wdata;
        flush_i = fl;
        neg();
        n = 0;
        while (!mem_gnt_o && n < 50) begin step(); neg(); n++; end
        check1("mem_gnt_seen", mem_gnt_o, 1'b1);
        step();
        mem_req_i = 0; mem_we_i = 0;
        neg();
        n = 0;
        while (!mem_valid_o && n < 50) begin step(); neg(); n++; end
        flush_i = 0;
        check1("mem_valid_seen", mem_valid_o, 1'b1);
        check32("mem_rdata", mem_rdata_o, exp_rdata);
    endtask

    task automatic fetch_txn(input logic [31:0] addr, input logic [31:0] rd, input bit fl);
        int n;
        step();
        rsp_data = rd; if_req_i = 1; if_addr_i = addr; flush_i = fl;
        neg();
        n = 0;
        while (!if_gnt_o && n < 50) begin step(); flush_i = 0; neg(); n++; end
        check1("fetch_gnt_seen", if_gnt_o, 1'b1);
        step();
        if_req_i = 0; flush_i = 0;
        neg();
        n = 0;
        while (!if_valid_o && n < 50) begin step(); neg(); n++; end
        check1("fetch_valid_seen", if_valid_o, 1'b1);
        check32("fetch_rdata", if_rdata_o, rd);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int mg, fg, mv;
        rst_n_i = 0;
        if_req_i = 0; if_addr_i = 0; flush_i = 0;
        mem_req_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
        repeat (3) @(posedge clk_i);
        neg();
        check32("reset_state", 32'(dbg_state_o), 32'd0);
        step();
        rst_n_i = 1;

        // single fetch, best-case latency
        step();
        rsp_data = 32'hDEAD_BEEF; if_req_i = 1; if_addr_i = 32'h0000_0040;
        neg();
        check1("t1_gnt_n0", if_gnt_o, 1'b0);
        check1("t1_stall_n0", fetch_stall_o, 1'b1);
        step(); neg();
        check1("t1_gnt_n1", if_gnt_o, 1'b1);
        check1("t1_preq_n1", port_req_o, 1'b1);
        check32("t1_addr_n1", port_addr_o, 32'h40);
        check1("t1_we_n1", port_we_o, 1'b0);
        step(); if_req_i = 0; neg();
        check1("t1_preq_n2", port_req_o, 1'b0);
        check32("t1_state_n2", 32'(dbg_state_o), 32'd2);
        check1("t1_valid_n2", if_valid_o, 1'b0);
        step(); neg();
        check1("t1_valid_n3", if_valid_o, 1'b1);
        check32("t1_rdata_n3", if_rdata_o, 32'hDEAD_BEEF);
        check32("t1_state_n3", 32'(dbg_state_o), 32'd0);
        step(); neg();
        check1("t1_valid_n4", if_valid_o, 1'b0);
        check32("t1_rdata_n4", if_rdata_o, 32'hDEAD_BEEF);

        // mem read to establish mem_rdata
        mem_txn(1'b0, 32'h200, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);

        // simultaneous: mem write wins, fetch follows
        step();
        rsp_data = 32'h7777_0000;
        mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h100; mem_wdata_i = 32'h55;
        if_req_i = 1; if_addr_i = 32'h80;
        neg();
        step(); neg();
        check1("t2_mem_gnt", mem_gnt_o, 1'b1);
        check1("t2_if_gnt0", if_gnt_o, 1'b0);
        check1("t2_we", port_we_o, 1'b1);
        check32("t2_wdata", port_wdata_o, 32'h55);
        check32("t2_addr", port_addr_o, 32'h100);
        step(); mem_req_i = 0; mem_we_i = 0; neg();
        step(); neg();
        check1("t2_mem_valid", mem_valid_o, 1'b1);
        check32("t2_mem_rdata_kept", mem_rdata_o, 32'hCAFE_F00D);
        check1("t2_if_gnt_early", if_gnt_o, 1'b0);
        step(); neg();
        check1("t2_if_gnt", if_gnt_o, 1'b1);
        check32("t2_if_addr", port_addr_o, 32'h80);
        step(); if_req_i = 0; neg();
        step(); neg();
        check1("t2_if_valid", if_valid_o, 1'b1);
        check32("t2_if_rdata", if_rdata_o, 32'h7777_0000);

        // flush during WAIT drops the response
        rsp_gap = 2;
        step();
        rsp_data = 32'h0000_1234; if_req_i = 1; if_addr_i = 32'hC0;
        step(); neg();
        check1("t3_gnt", if_gnt_o, 1'b1);
        step(); if_req_i = 0; flush_i = 1; neg();
        check32("t3_state_wait", 32'(dbg_state_o), 32'd2);
        step(); flush_i = 0;
        for (int k = 0; k < 6; k++) begin
            neg();
            check1("t3_no_valid", if_valid_o, 1'b0);
            check32("t3_rdata_held", if_rdata_o, 32'h7777_0000);
            step();
        end
        neg();
        check32("t3_state_idle", 32'(dbg_state_o), 32'd0);
        rsp_gap = 0;

        // flush in IDLE and with mem owner has no effect
        fetch_txn(32'h44, 32'hABCD_0001, 1'b1);
        mem_txn(1'b0, 32'h204, 32'h0, 32'h5A5A_0F0F, 32'h5A5A_0F0F, 1'b1);

        // ready held low for five ISSUE cycles
        ready_wait = 5;
        step();
        rsp_data = 32'h3030_3030; if_req_i = 1; if_addr_i = 32'h300;
        step(); neg();
        check1("t5_gnt", if_gnt_o, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin step(); neg(); end
            if (k == 1) if_req_i = 0;
            check1("t5_preq_stable", port_req_o, 1'b1);
            check32("t5_addr_stable", port_addr_o, 32'h300);
            check1("t5_ready_low", port_ready_i, 1'b0);
        end
        step(); neg();
        check1("t5_ready_high", port_ready_i, 1'b1);
        check1("t5_preq_at_accept", port_req_o, 1'b1);
        step(); neg();
        check1("t5_preq_wait", port_req_o, 1'b0);
        check32("t5_state_wait", 32'(dbg_state_o), 32'd2);
        step(); neg();
        check1("t5_valid", if_valid_o, 1'b1);
        check32("t5_rdata", if_rdata_o, 32'h3030_3030);
        ready_wait = 0;

        // reset in WAIT abandons the transaction
        rsp_gap = 3;
        step();
        rsp_data = 32'h0000_EEEE; if_req_i = 1; if_addr_i = 32'h500;
        step();
        step(); if_req_i = 0;
        neg();
        check32("t6_state_wait", 32'(dbg_state_o), 32'd2);
        #2;
        rst_n_i = 0; auto_rsp = 0; port_ready_i = 0; port_valid_i = 0;
        #1;
        check32("t6_async_state", 32'(dbg_state_o), 32'd0);
        check1("t6_async_preq", port_req_o, 1'b0);
        check32("t6_async_if_rdata", if_rdata_o, 32'h0);
        check32("t6_async_mem_rdata", mem_rdata_o, 32'h0);
        step(); step();
        rst_n_i = 1;
        step();
        port_valid_i = 1; port_rdata_i = 32'hFFFF_FFFF;
        neg();
        check32("t6_idle", 32'(dbg_state_o), 32'd0);
        for (int k = 0; k < 2; k++) begin
            step(); port_valid_i = 0; neg();
            check1("t6_no_if_valid", if_valid_o, 1'b0);
            check1("t6_no_mem_valid", mem_valid_o, 1'b0);
            check32("t6_if_rdata", if_rdata_o, 32'h0);
            check32("t6_mem_rdata", mem_rdata_o, 32'h0);
            check1("t6_preq", port_req_o, 1'b0);
        end
        auto_rsp = 1; rsp_gap = 0;

        // both requesters held high
        step();
        rsp_data = 32'h0F0F_0000;
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h600;
        if_req_i = 1; if_addr_i = 32'h700;
        mg = 0; fg = 0; mv = 0;
        for (int k = 0; k < 300; k++) begin
            neg();
            if (mem_gnt_o) mg++;
            if (mem_valid_o) mv++;
            if (if_gnt_o) begin
                fg++;
                break;
            end
            if (mv >= 20) break;
            step();
        end
`ifdef FETCH_STARVE_GUARD_EN
        check32("t7_mem_grants_before_fetch", 32'(mg), 32'd4);
        check32("t7_fetch_granted", 32'(fg), 32'd1);
`else
        check32("t7_mem_txns", 32'(mv), 32'd20);
        check32("t7_no_fetch_grant", 32'(fg), 32'd0);
`endif
        step();
        mem_req_i = 0; if_req_i = 0;
        repeat (10) step();
        neg();
        check32("t7_final_idle", 32'(dbg_state_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
